// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed, checksummed byte stream into
// little-endian 32-bit words, writes them to instruction memory and then releases the core.
module imem_loader #(
  parameter int NUM_INSTR = 1024,
  parameter int ADDR_W    = $clog2(NUM_INSTR)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_n_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W-1:0]   last_idx_q, last_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [31:0]         word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                byte_ready_q, byte_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_n_rst_q, core_n_rst_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic [15:0]         n_full;

  assign accept = byte_valid & byte_ready_q;
  assign n_full = {byte_in, len_lo_q};

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    last_idx_d   = last_idx_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = byte_in;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          if (n_full == 16'd0 || 32'(n_full) > NUM_INSTR) begin
            state_d = ERROR;
          end else begin
            // Storing N-1 keeps the index compare within ADDR_W bits even when N == NUM_INSTR.
            last_idx_d = ADDR_W'(n_full - 16'd1);
            word_idx_d = '0;
            byte_idx_d = '0;
            csum_d     = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_d                   = csum_q + byte_in;
          word_d[8*byte_idx_q +: 8] = byte_in;
          byte_idx_d               = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = {byte_in, word_q[23:0]};
            word_idx_d   = word_idx_q + 1'b1;
            if (word_idx_q == last_idx_q) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (accept) state_d = (byte_in == csum_q) ? RUN : ERROR;
      end
      RUN: begin
        if (start) state_d = LEN_LO;
      end
      ERROR: begin
        if (start) state_d = LEN_LO;
      end
      default: state_d = IDLE;
    endcase

    byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                   (state_d == DATA)   || (state_d == CHECK);
    // The core is only released once RUN has been held for a full cycle.
    done_d       = (state_q == RUN) && (state_d == RUN);
    core_n_rst_d = done_d;
    error_d      = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      last_idx_q   <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_n_rst_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      last_idx_q   <= last_idx_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_n_rst_q <= core_n_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_n_rst = core_n_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed frames drive the byte stream while a
// negedge monitor checks every memory write against a queue of expected writes.
module tb_imem_loader;

  localparam int NUM_INSTR = 1024;
  localparam int ADDR_W    = $clog2(NUM_INSTR);

  logic              clk;
  logic              n_rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_n_rst;
  logic              done;
  logic              error;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  frame[$];

  imem_loader #(.NUM_INSTR(NUM_INSTR)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_n_rst (core_n_rst),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (n_rst && imem_we) begin
      if (exp_addr.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h, expected no write", imem_addr, imem_wdata);
      end else begin
        checkOutput("write_addr", 32'(imem_addr), exp_addr.pop_front());
        checkOutput("write_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    exp_addr.push_back(addr);
    exp_data.push_back(data);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends one byte, optionally preceded by a random idle gap with junk on byte_in.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL byte_ready_timeout: got byte_ready 0, expected 1 within 50 cycles");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) sendByte(bytes[i], gaps);
  endtask

  task automatic expectRunning(input string tag);
    checkOutput({tag, "_done_first_cycle"}, 32'(done), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_core_n_rst"}, 32'(core_n_rst), 32'd1);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic loadTwoWords(input string tag, input bit gaps);
    expectWrite(32'd0, 32'h0050_0093);
    expectWrite(32'd1, 32'h0010_8113);
    pulseStart();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h87};
    applyStimulus(frame, gaps);
    expectRunning(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_rst      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("reset_core_n_rst", 32'(core_n_rst), 32'd0);
    checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
    n_rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Test 1: two-word load.
    loadTwoWords("t1", 1'b0);

    // Test 2: bad checksum, then a correct reload.
    expectWrite(32'd0, 32'h0050_0093);
    expectWrite(32'd1, 32'h0010_8113);
    pulseStart();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h88};
    applyStimulus(frame, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("t2_error", 32'(error), 32'd1);
    checkOutput("t2_done", 32'(done), 32'd0);
    checkOutput("t2_core_n_rst", 32'(core_n_rst), 32'd0);
    checkOutput("t2_pending_writes", 32'(exp_addr.size()), 32'd0);
    loadTwoWords("t2_reload", 1'b0);

    // Test 3: zero length and N = 1025 both fail right after len_hi.
    pulseStart();
    checkOutput("t3_error_cleared", 32'(error), 32'd0);
    frame = '{8'h00, 8'h00};
    applyStimulus(frame, 1'b0);
    checkOutput("t3_zero_error", 32'(error), 32'd1);
    checkOutput("t3_zero_byte_ready", 32'(byte_ready), 32'd0);
    pulseStart();
    checkOutput("t3_error_cleared2", 32'(error), 32'd0);
    frame = '{8'h01, 8'h04};
    applyStimulus(frame, 1'b0);
    checkOutput("t3_big_error", 32'(error), 32'd1);
    checkOutput("t3_big_byte_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_core_n_rst", 32'(core_n_rst), 32'd0);

    // Test 4: same image with random valid gaps.
    loadTwoWords("t4", 1'b1);

    // Test 5: asynchronous reset after the 5th payload byte.
    expectWrite(32'd0, 32'h0050_0093);
    pulseStart();
    frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13};
    applyStimulus(frame, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("t5_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("t5_imem_we", 32'(imem_we), 32'd0);
    checkOutput("t5_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("t5_imem_wdata", imem_wdata, 32'd0);
    checkOutput("t5_core_n_rst", 32'(core_n_rst), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_error", 32'(error), 32'd0);
    checkOutput("t5_pending_writes", 32'(exp_addr.size()), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    loadTwoWords("t5_restart", 1'b0);

    // Test 6: reload a one-word image straight from RUN.
    expectWrite(32'd0, 32'h0000_0013);
    pulseStart();
    checkOutput("t6_done_drop", 32'(done), 32'd0);
    checkOutput("t6_core_n_rst_drop", 32'(core_n_rst), 32'd0);
    frame = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    applyStimulus(frame, 1'b0);
    expectRunning("t6");

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory that the core's fetch stage reads.
- Accepts a byte stream over a valid/ready interface (fed by a UART RX or a test bench), assembles little-endian 32-bit instruction words and writes them into instruction memory.
- Holds the core in reset until a complete image with a valid checksum has been written, then releases it.

Parameters:
NUM_INSTR, 1024, instruction memory depth in words; maximum legal image length.
ADDR_W, $clog2(NUM_INSTR), width of the word address to instruction memory.

Ports:
clk  input  1  system clock; all state updates on posedge.
n_rst  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins a load from IDLE, RUN or ERROR.
byte_in  input  8  stream byte.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader can accept a byte this cycle.
imem_we  output  1  instruction memory write strobe, one cycle per word.
imem_addr  output  ADDR_W  word index being written.
imem_wdata  output  32  assembled instruction word.
core_n_rst  output  1  active-low reset to the core; low while not in RUN.
done  output  1  image loaded and verified; core running.
error  output  1  load failed (length or checksum).

Behaviour:
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_n_rst=0, done=0, error=0, state=IDLE.
- Reset is asynchronous at any time, including mid-load: all outputs return to reset values immediately. Partially written memory contents are not cleared.
- A byte is accepted only on a cycle with byte_valid & byte_ready.
- byte_ready is a registered function of state: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 elsewhere.

Frame format:
- len_lo, len_hi: N = {len_hi, len_lo}, unsigned 16 bits.
- 4N payload bytes, least-significant byte of each word first.
- One checksum byte: sum of all payload bytes mod 256. Length bytes are not included.

State machine:
- IDLE: start -> LEN_LO. Other inputs are ignored.
- LEN_LO: on accept, latch the low byte -> LEN_HI.
- LEN_HI: on accept, form N.
  - N==0 or N>NUM_INSTR -> ERROR.
  - Otherwise clear the word counter, byte counter and checksum -> DATA.
- DATA: each accepted byte is shifted into bits [8k+7:8k] of the word (k = byte index 0..3) and added to the checksum.
  - On the 4th byte of a word: next cycle imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = the full word. The word index then increments.
  - After word N-1's 4th byte -> CHECK.
  - byte_ready may stay high during the write cycle; back-to-back bytes at full rate are supported.
- CHECK: on accept, compare against the checksum.
  - Match -> RUN.
  - Mismatch -> ERROR.
- RUN: core_n_rst=1 and done=1, both registered. They rise the cycle after entering RUN, i.e. two cycles after the checksum byte is accepted. start -> LEN_LO, and core_n_rst/done drop low the next cycle.
- ERROR: error=1, core_n_rst=0. start -> LEN_LO and error clears.
- start is ignored in LEN_LO, LEN_HI, DATA and CHECK.
- Gaps with byte_valid=0 stall the FSM indefinitely. There is no timeout.
- imem_addr wraps nowhere: N is bounded to NUM_INSTR, so the maximum index is NUM_INSTR-1.
- imem_addr and imem_wdata hold their last written values when imem_we=0.

Test Plan:
1. Two-word load. Stimulus: reset, start, bytes 02 00 93 00 50 00 13 81 10 00 87.
   Required: imem_we at addr 0 with 0x00500093, then addr 1 with 0x00108113; core_n_rst=1 and done=1 two cycles after byte 87.
2. Bad checksum. Stimulus: same stream with checksum 88.
   Required: both words still written; error=1, core_n_rst stays 0, done=0. Then start plus the correct stream gives done=1.
3. Illegal length. Stimulus: length 00 00, and separately 01 04 (N=1025).
   Required: ERROR immediately after len_hi; no imem_we pulse; byte_ready=0.
4. Back-pressure and gaps. Stimulus: the test 1 stream with byte_valid toggled randomly 0/1.
   Required: identical writes and result; no byte is double-counted while byte_valid=0.
5. Reset mid-load. Stimulus: assert n_rst low after the 5th payload byte.
   Required: all outputs at reset values in the same cycle; a full restart then completes as in test 1.
6. Reload from RUN. Stimulus: start pulse while done=1, then a one-word image (01 00 13 00 00 00 13).
   Required: core_n_rst low the next cycle; addr 0 gets 0x00000013; done=1 again.
